// File: rtl/sram_controller.sv
// Two-phase 32-bit load/store sequencer onto a 16-bit asynchronous SRAM.
// Low half-word first, then high half-word; ready stays low until the DONE cycle.
module sram_controller #(
  parameter int WORD_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int SRAM_DATA_WIDTH = 16,
  parameter int WAIT_CYCLES     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [WORD_WIDTH-1:0]      address,
  input  logic [WORD_WIDTH-1:0]      write_data,
  output logic [WORD_WIDTH-1:0]      read_data,
  output logic                       ready,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic                       SRAM_WE_N,
  output logic [SRAM_DATA_WIDTH-1:0] SRAM_DQ_out,
  output logic                       SRAM_DQ_oe,
  input  logic [SRAM_DATA_WIDTH-1:0] SRAM_DQ_in,
  output logic [1:0]                 o_dbg_state
);

  localparam int SAW = SRAM_ADDR_WIDTH;
  localparam int SDW = SRAM_DATA_WIDTH;
  localparam int IW  = SAW - 1;
  localparam int CW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_index;
  logic [SDW-1:0]      r_wdata_hi;
  logic                r_is_wr;
  logic [WORD_WIDTH-1:0] r_read_data;
  logic [SAW-1:0]      r_sram_addr;
  logic                r_sram_we_n;
  logic [SDW-1:0]      r_sram_dq_out;
  logic                r_sram_dq_oe;

  logic                w_req;
  logic [IW-1:0]       w_index;
  logic                w_unused;

  assign w_req    = rd_en | wr_en;
  assign w_index  = address[SAW:2];
  // Byte-lane and upper address bits have no meaning for a word-only SRAM port.
  assign w_unused = ^{address[WORD_WIDTH-1:SAW+1], address[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_index       <= '0;
      r_wdata_hi    <= '0;
      r_is_wr       <= 1'b0;
      r_read_data   <= '0;
      r_sram_addr   <= '0;
      r_sram_we_n   <= 1'b1;
      r_sram_dq_out <= '0;
      r_sram_dq_oe  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            // A simultaneous rd_en/wr_en resolves to a write.
            r_index       <= w_index;
            r_wdata_hi    <= write_data[WORD_WIDTH-1:SDW];
            r_is_wr       <= wr_en;
            r_cnt         <= RELOAD;
            r_state       <= LOW;
            r_sram_addr   <= {w_index, 1'b0};
            r_sram_we_n   <= ~wr_en;
            r_sram_dq_oe  <= wr_en;
            r_sram_dq_out <= wr_en ? write_data[SDW-1:0] : '0;
          end
        end
        LOW: begin
          if (r_cnt == '0) begin
            if (!r_is_wr) r_read_data[SDW-1:0] <= SRAM_DQ_in;
            r_cnt         <= RELOAD;
            r_state       <= HIGH;
            r_sram_addr   <= {r_index, 1'b1};
            r_sram_dq_out <= r_is_wr ? r_wdata_hi : '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HIGH: begin
          if (r_cnt == '0) begin
            if (!r_is_wr) r_read_data[WORD_WIDTH-1:SDW] <= SRAM_DQ_in;
            r_state       <= DONE;
            r_sram_addr   <= '0;
            r_sram_we_n   <= 1'b1;
            r_sram_dq_oe  <= 1'b0;
            r_sram_dq_out <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ready is combinational so the freeze asserts in the same cycle the request appears.
  assign ready       = (r_state == DONE) || ((r_state == IDLE) && !w_req);
  assign read_data   = r_read_data;
  assign SRAM_ADDR   = r_sram_addr;
  assign SRAM_WE_N   = r_sram_we_n;
  assign SRAM_DQ_out = r_sram_dq_out;
  assign SRAM_DQ_oe  = r_sram_dq_oe;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: W=2 instance with an SRAM model, plus a W=1 instance.
module tb_sram_controller;

  logic        clk;
  logic        rst;

  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe;
  logic [1:0]  dbg_state;

  logic        rd_en_1, wr_en_1;
  logic [31:0] address_1, write_data_1, read_data_1;
  logic        ready_1;
  logic [17:0] sram_addr_1;
  logic        sram_we_n_1;
  logic [15:0] sram_dq_out_1, sram_dq_in_1;
  logic        sram_dq_oe_1;
  logic [1:0]  dbg_state_1;

  int n_tests = 0;
  int n_fail  = 0;

  sram_controller #(.WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n), .SRAM_DQ_out(sram_dq_out),
    .SRAM_DQ_oe(sram_dq_oe), .SRAM_DQ_in(sram_dq_in), .o_dbg_state(dbg_state)
  );

  sram_controller #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en_1), .wr_en(wr_en_1),
    .address(address_1), .write_data(write_data_1), .read_data(read_data_1), .ready(ready_1),
    .SRAM_ADDR(sram_addr_1), .SRAM_WE_N(sram_we_n_1), .SRAM_DQ_out(sram_dq_out_1),
    .SRAM_DQ_oe(sram_dq_oe_1), .SRAM_DQ_in(sram_dq_in_1), .o_dbg_state(dbg_state_1)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural asynchronous SRAM for the W=2 instance
  logic [15:0] mem [0:1023];
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[9:0]] <= sram_dq_out;
  end
  assign sram_dq_in = sram_dq_oe ? 16'h0000 : mem[sram_addr[9:0]];

  // Address-derived data pattern for the W=1 instance
  assign sram_dq_in_1 = sram_addr_1[15:0] ^ 16'hA5A5;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    rd_en_1 = 0; wr_en_1 = 0; address_1 = 0; write_data_1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
    n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n got=%b exp=1", sram_we_n); end
    n_tests++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", sram_dq_oe); end
    n_tests++; if (sram_addr !== 18'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
    n_tests++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_read_data got=%h exp=0", read_data); end
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_write();
    logic [17:0] ea;
    logic [15:0] ed;
    next_cycle();
    wr_en = 1; address = 32'h0000_0408; write_data = 32'hDEADBEEF;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      ea = (c >= 1 && c <= 2) ? 18'h00204 : (c >= 3 && c <= 4) ? 18'h00205 : 18'h0;
      ed = (c >= 1 && c <= 2) ? 16'hBEEF : (c >= 3 && c <= 4) ? 16'hDEAD : 16'h0;
      n_tests++; if (sram_addr !== ea) begin n_fail++; $display("FAIL wr_addr c=%0d got=%h exp=%h", c, sram_addr, ea); end
      n_tests++; if (sram_dq_out !== ed) begin n_fail++; $display("FAIL wr_dq c=%0d got=%h exp=%h", c, sram_dq_out, ed); end
      n_tests++; if (sram_we_n !== !(c >= 1 && c <= 4)) begin n_fail++; $display("FAIL wr_we_n c=%0d got=%b", c, sram_we_n); end
      n_tests++; if (sram_dq_oe !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL wr_oe c=%0d got=%b", c, sram_dq_oe); end
      n_tests++; if (ready !== (c == 5)) begin n_fail++; $display("FAIL wr_ready c=%0d got=%b", c, ready); end
      next_cycle();
    end
    wr_en = 0;
    n_tests++; if (mem[10'h204] !== 16'hBEEF) begin n_fail++; $display("FAIL wr_mem_lo got=%h exp=beef", mem[10'h204]); end
    n_tests++; if (mem[10'h205] !== 16'hDEAD) begin n_fail++; $display("FAIL wr_mem_hi got=%h exp=dead", mem[10'h205]); end
  endtask

  task automatic test_read();
    next_cycle();
    rd_en = 1; address = 32'h0000_0408;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_tests++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rd_oe c=%0d got=%b exp=0", c, sram_dq_oe); end
      n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rd_we_n c=%0d got=%b exp=1", c, sram_we_n); end
      n_tests++; if (ready !== (c == 5)) begin n_fail++; $display("FAIL rd_ready c=%0d got=%b", c, ready); end
      if (c == 5) begin
        n_tests++; if (read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=deadbeef", read_data); end
      end
      next_cycle();
    end
    rd_en = 0;
    repeat (3) next_cycle();
    @(negedge clk);
    n_tests++; if (read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold got=%h exp=deadbeef", read_data); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    wr_en = 1; address = 32'h0000_040C; write_data = 32'hCAFEF00D;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_tests++; if (ready !== (c == 5)) begin n_fail++; $display("FAIL b2b_wr_ready c=%0d got=%b", c, ready); end
      next_cycle();
    end
    // Read request appears in the cycle right after the write's DONE
    wr_en = 0; rd_en = 1; address = 32'h0000_040C;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_tests++; if (ready !== (c == 5)) begin n_fail++; $display("FAIL b2b_rd_ready c=%0d got=%b", c, ready); end
      if (c == 1) begin
        n_tests++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL b2b_low_start got=%0d exp=1", dbg_state); end
        n_tests++; if (sram_addr !== 18'h00206) begin n_fail++; $display("FAIL b2b_rd_addr got=%h exp=00206", sram_addr); end
      end
      if (c == 5) begin
        n_tests++; if (read_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_rd_data got=%h exp=cafef00d", read_data); end
      end
      next_cycle();
    end
    rd_en = 0;
  endtask

  task automatic test_conflict();
    next_cycle();
    rd_en = 1; wr_en = 1; address = 32'h0000_0410; write_data = 32'h0BADCAFE;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_tests++; if (sram_we_n !== !(c >= 1 && c <= 4)) begin n_fail++; $display("FAIL cf_we_n c=%0d got=%b", c, sram_we_n); end
      n_tests++; if (read_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL cf_read_data c=%0d got=%h exp=cafef00d", c, read_data); end
      next_cycle();
    end
    rd_en = 0; wr_en = 0;
    n_tests++; if (mem[10'h208] !== 16'hCAFE) begin n_fail++; $display("FAIL cf_mem_lo got=%h exp=cafe", mem[10'h208]); end
    n_tests++; if (mem[10'h209] !== 16'h0BAD) begin n_fail++; $display("FAIL cf_mem_hi got=%h exp=0bad", mem[10'h209]); end
  endtask

  task automatic test_reset_mid_access();
    int  low_cnt;
    bit  done;
    next_cycle();
    wr_en = 1; address = 32'h0000_0418; write_data = 32'h11112222;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      next_cycle();
    end
    rst = 1; wr_en = 0;
    @(negedge clk);
    n_tests++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL rm_in_high got=%0d exp=2", dbg_state); end
    n_tests++; if (sram_addr !== 18'h0020D) begin n_fail++; $display("FAIL rm_high_addr got=%h exp=0020d", sram_addr); end
    next_cycle();
    rst = 0;
    @(negedge clk);
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rm_state got=%0d exp=0", dbg_state); end
    n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rm_we_n got=%b exp=1", sram_we_n); end
    n_tests++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rm_oe got=%b exp=0", sram_dq_oe); end
    n_tests++; if (sram_addr !== 18'h0) begin n_fail++; $display("FAIL rm_addr got=%h exp=0", sram_addr); end
    n_tests++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL rm_read_data got=%h exp=0", read_data); end
    next_cycle();
    rd_en = 1; address = 32'h0000_0408;
    low_cnt = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (ready) done = 1;
      else begin
        low_cnt++;
        next_cycle();
      end
    end
    n_tests++; if (!done) begin n_fail++; $display("FAIL rm_timeout got=no_ready exp=ready"); end
    n_tests++; if (low_cnt != 5) begin n_fail++; $display("FAIL rm_stall got=%0d exp=5", low_cnt); end
    n_tests++; if (read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rm_rd_data got=%h exp=deadbeef", read_data); end
    next_cycle();
    rd_en = 0;
  endtask

  task automatic test_w1();
    int low_cnt;
    next_cycle();
    rd_en_1 = 1; address_1 = 32'h0000_0020;
    low_cnt = 0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (!ready_1) low_cnt++;
      n_tests++; if (dbg_state_1 !== 2'(c)) begin n_fail++; $display("FAIL w1_state c=%0d got=%0d exp=%0d", c, dbg_state_1, c); end
      n_tests++; if (ready_1 !== (c == 3)) begin n_fail++; $display("FAIL w1_ready c=%0d got=%b", c, ready_1); end
      if (c == 1) begin
        n_tests++; if (sram_addr_1 !== 18'h00010) begin n_fail++; $display("FAIL w1_addr_lo got=%h exp=00010", sram_addr_1); end
      end
      if (c == 2) begin
        n_tests++; if (sram_addr_1 !== 18'h00011) begin n_fail++; $display("FAIL w1_addr_hi got=%h exp=00011", sram_addr_1); end
      end
      if (c == 3) begin
        n_tests++; if (read_data_1 !== 32'hA5B4A5B5) begin n_fail++; $display("FAIL w1_data got=%h exp=a5b4a5b5", read_data_1); end
      end
      next_cycle();
    end
    rd_en_1 = 0;
    n_tests++; if (low_cnt != 3) begin n_fail++; $display("FAIL w1_stall got=%0d exp=3", low_cnt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_conflict();
    test_reset_mid_access();
    test_w1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
